// File: rtl/memory_writer.sv
// Write-back engine: pops PE results and stores them to consecutive word addresses.
// Optional feature: define MEM_WRITER_CHECKSUM_EN to add an XOR checksum output.
module memory_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              src_empty,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
`ifdef MEM_WRITER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [CNT_W-1:0]  words_written
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPTURE,
        WRITE,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  count_inc;
    logic              accept;
    logic              commit;

    assign count_inc = words_written + CNT_W'(1);
    assign accept    = (state == IDLE) && start;
    assign commit    = mem_we && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        src_rd     = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (num_words == '0) ? FINISH : POP;
                end
            end
            POP: begin
                // Pop only when data exists, so one pop is ever in flight
                if (!src_empty) begin
                    src_rd     = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = WRITE;
            WRITE: begin
                mem_we = 1'b1;
                if (mem_ready) begin
                    state_next = (count_inc == target) ? FINISH : POP;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr      <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
            target        <= '0;
        end else begin
            if (accept) begin
                mem_addr      <= base_addr & ~ADDR_W'(3);
                target        <= num_words;
                words_written <= '0;
            end
            if (state == CAPTURE) begin
                mem_wdata <= src_data;
            end
            if (commit) begin
                mem_addr      <= mem_addr + ADDR_W'(4);
                words_written <= count_inc;
            end
        end
    end

`ifdef MEM_WRITER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (commit) begin
            checksum <= checksum ^ mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_memory_writer.sv
// Directed self-checking bench for memory_writer.
// Optional checksum checks compile in when MEM_WRITER_CHECKSUM_EN is defined.
module tb_memory_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        src_empty;
    logic [31:0] src_data;
    logic        src_rd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [15:0] words_written;
`ifdef MEM_WRITER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    memory_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .src_empty     (src_empty),
        .src_data      (src_data),
        .src_rd        (src_rd),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .done          (done),
`ifdef MEM_WRITER_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Source buffer model: vector plus read index, with an external hold.
    logic [31:0] src_vec [16];
    int          n_src;
    int          rd_idx;
    logic        hold;
    int          rd_viol;

    assign src_empty = hold || (rd_idx >= n_src);

    always @(posedge clk) begin
        if (src_rd && rd_idx < n_src) begin
            src_data <= src_vec[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    // Commit log, sampled mid-cycle; mem_ready changes only after posedges.
    logic [31:0] wa [32];
    logic [31:0] wd [32];
    int          nw;
    int          done_cnt;

    always @(negedge clk) begin
        if (mem_we && mem_ready && nw < 32) begin
            wa[nw] = mem_addr;
            wd[nw] = mem_wdata;
            nw++;
        end
        if (done) done_cnt++;
        if (src_rd && src_empty) rd_viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input int n);
        src_vec[0] = d0;
        src_vec[1] = d1;
        src_vec[2] = d2;
        src_vec[3] = d3;
        n_src  = n;
        rd_idx = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        nw        = 0;
        done_cnt  = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns negedges counted after the start edge until done is seen.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 200);
        if (!done) chk({tag, "_timeout"}, 64'(cyc), 64'd0);
    endtask

    int cyc;
    int bad;
    int stall;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        mem_ready = 1'b1;
        hold      = 1'b0;
        src_data  = '0;
        rd_viol   = 0;
        nw        = 0;
        done_cnt  = 0;
        load(0, 0, 0, 0, 0);
        #2;
        chk("rst_ctl", {60'd0, mem_we, busy, done, src_rd}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_cnt", 64'(words_written), 64'd0);
        #20;
        rst_n = 1'b1;

        // Basic: 4 words, no stalls, 3 cycles per word plus FINISH
        load(32'hA, 32'hB, 32'hC, 32'hD, 4);
        do_start(32'h100, 16'd4);
        wait_done("basic", cyc);
        chk("basic_cycles", 64'(cyc), 64'd13);
        chk("basic_busy_at_done", 64'(busy), 64'd1);
        chk("basic_wcount", 64'(words_written), 64'd4);
        @(negedge clk);
        chk("basic_busy_after", {62'd0, busy, done}, 64'd0);
        chk("basic_nw", 64'(nw), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_addr", 64'(wa[i]), 64'(32'h100 + 4 * i));
            chk("basic_data", 64'(wd[i]), 64'(32'hA + i));
        end
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        repeat (3) @(negedge clk);
        chk("hold_wcount", 64'(words_written), 64'd4);

        // Stall: mem_ready low across the second write
        load(32'h11, 32'h22, 32'h33, 32'h44, 4);
        do_start(32'h200, 16'd4);
        cyc = 0;
        while (nw < 1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        stall = 0;
        cyc   = 0;
        while (stall < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                stall++;
                chk("stall_addr", 64'(mem_addr), 64'h204);
                chk("stall_data", 64'(mem_wdata), 64'h22);
                chk("stall_rd", 64'(src_rd), 64'd0);
            end
        end
        chk("stall_seen", 64'(stall), 64'd5);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        wait_done("stall", cyc);
        chk("stall_nw", 64'(nw), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("stall_addr_w", 64'(wa[i]), 64'(32'h200 + 4 * i));
            chk("stall_data_w", 64'(wd[i]), 64'(32'h11 * (i + 1)));
        end

        // Empty source: 6 cycles with nothing to pop
        load(32'h5, 32'h6, 0, 0, 2);
        hold = 1'b1;
        do_start(32'h300, 16'd2);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (src_rd || mem_we) bad++;
        end
        chk("empty_idle", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done("empty", cyc);
        chk("empty_nw", 64'(nw), 64'd2);
        chk("empty_w0", {wa[0], wd[0]}, {32'h300, 32'h5});
        chk("empty_w1", {wa[1], wd[1]}, {32'h304, 32'h6});

        // Zero-length transfer
        do_start(32'h400, 16'd0);
        wait_done("zero", cyc);
        chk("zero_done_fast", 64'(cyc <= 2), 64'd1);
        @(negedge clk);
        chk("zero_nw", 64'(nw), 64'd0);
        chk("zero_wcount", 64'(words_written), 64'd0);

        // Address wrap past all-ones
        load(32'h1, 32'h2, 0, 0, 2);
        do_start(32'hFFFF_FFFC, 16'd2);
        wait_done("wrap", cyc);
        chk("wrap_a0", 64'(wa[0]), 64'hFFFF_FFFC);
        chk("wrap_a1", 64'(wa[1]), 64'h0);

        // Misaligned base is forced to a word boundary
        load(32'h77, 0, 0, 0, 1);
        do_start(32'h103, 16'd1);
        wait_done("align", cyc);
        chk("align_w0", {wa[0], wd[0]}, {32'h100, 32'h77});

`ifdef MEM_WRITER_CHECKSUM_EN
        load(32'h0F, 32'hF0, 32'hFF, 0, 3);
        do_start(32'h500, 16'd3);
        wait_done("csum", cyc);
        chk("csum_zero", 64'(checksum), 64'h0);
        load(32'h12, 32'h34, 0, 0, 2);
        do_start(32'h600, 16'd2);
        wait_done("csum2", cyc);
        chk("csum_val", 64'(checksum), 64'h26);
        load(32'h99, 0, 0, 0, 1);
        do_start(32'h700, 16'd1);
        chk("csum_clear", 64'(checksum), 64'h0);
        wait_done("csum3", cyc);
`endif

        // Reset mid-WRITE aborts; no writes afterwards without start
        load(32'h1, 32'h2, 32'h3, 32'h4, 4);
        do_start(32'h800, 16'd4);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_we && cyc < 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", {60'd0, mem_we, busy, done, src_rd}, 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_data", 64'(mem_wdata), 64'd0);
        chk("arst_cnt", 64'(words_written), 64'd0);
        @(negedge clk);
        nw = 0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_write", 64'(nw), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);

        chk("rd_while_empty", 64'(rd_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_writer.md
Name: memory_writer

Overview:
- Write-back engine; the opposite direction of Memory_Reader.
- Pops finished results from ProcessingElementMod's output buffer (out/out_empty side) and stores them to data memory at consecutive word addresses.
- Sits between the PE result buffer and the memory write port.
- Started by the controller with a base address and a word count; reports busy, done and progress.

Parameters:
DATA_W, 32, width of one result word and of memory write data
ADDR_W, 32, width of the byte address
CNT_W, 16, width of the word count and progress counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; latches base_addr and num_words
base_addr  in  ADDR_W  byte address of the first word (word aligned)
num_words  in  CNT_W  number of words to transfer
src_empty  in  1  PE output buffer empty
src_data  in  DATA_W  PE output word, valid the cycle after src_rd
src_rd  out  1  pop request to the PE output buffer
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts the write in a cycle where mem_we && mem_ready
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the transfer completes
words_written  out  CNT_W  words committed in the current or last transfer

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - src_rd, mem_we, busy and done = 0.
  - mem_addr, mem_wdata and words_written = 0.
- Reset mid-transfer aborts immediately; no partial write is completed.
- FSM states:
  - IDLE:
    - start=1 latches base_addr into the address register and num_words into the target register, and clears words_written.
    - If num_words==0, go to FINISH; otherwise go to POP.
  - POP:
    - src_rd = !src_empty (combinational from state).
    - If src_empty=1, stay in POP with no pop.
    - If src_empty=0, move to CAPTURE.
  - CAPTURE: register src_data into mem_wdata, then go to WRITE.
  - WRITE:
    - mem_we=1; mem_addr and mem_wdata are held stable while mem_ready=0.
    - On mem_we && mem_ready: mem_addr += 4, words_written += 1.
    - If the incremented count equals the target, go to FINISH; otherwise go to POP.
  - FINISH: done=1 for exactly one cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- Throughput: one word per 3 cycles with no stalls. Latency from start to the first mem_we is 3 cycles when src_empty=0.
- start is ignored when not in IDLE.
- start in the FINISH cycle is ignored; it is accepted from the next IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap past all-ones is silent.
- The low 2 bits of base_addr are forced to 0 when latched.
- words_written holds its final value after done, until the next accepted start.
- src_rd is never asserted while src_empty=1. At most one pop is outstanding.

Optional Feature:
- Macro: MEM_WRITER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (DATA_W).
  - Cleared to 0 on reset and on accepted start.
  - XOR-accumulates mem_wdata on every committed write (mem_we && mem_ready).
  - Valid and stable from the done pulse until the next accepted start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst_n=0 mid-WRITE -> all outputs 0 asynchronously; after release, no mem_we until a new start.
- Basic transfer: base_addr=0x100, num_words=4, src_empty=0, data 0xA,0xB,0xC,0xD, mem_ready=1.
  - Expected: writes to 0x100/0x104/0x108/0x10C with matching data.
  - Expected: words_written=4; one done pulse; busy drops the cycle after done.
- Stalls: mem_ready=0 for 5 cycles on the second write -> mem_we/addr/data held constant; src_rd=0 throughout; completes with correct data.
- Empty source: src_empty=1 for 6 cycles in POP -> src_rd stays 0, no writes; transfer resumes and completes when src_empty falls.
- Edge cases:
  - num_words=0 -> done pulse 2 cycles after start, zero writes.
  - base_addr=0xFFFFFFFC with num_words=2 -> second write at 0x00000000.
  - base_addr=0x103 -> first write at 0x100.
- Checksum (with MEM_WRITER_CHECKSUM_EN): data 0x0F,0xF0,0xFF -> checksum=0x00 at done; a second start clears it to 0.
